mem_access_unit: RTL and testbench

Memory-access and instruction/data register stage of the multicycle MIPS datapath, directly downstream of the control FSM. Converts the control unit's per-cycle memory commands (InstData, MemRead, MemWrite, IRWrite) into a request/acknowledge transaction on a unified instruction/data memory bus. Captures fetched words into the instruction register (IR) or memory data register (MDR). Decodes IR fields (opc, fnc, ...) back to the control unit, and raises busy so the controller stalls until the access completes.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/ir_decode.sv | 25 ++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath.
// Holds the memory-access FSM states, sticky error codes, instruction field
// bit positions and the opcode constants already used by the control FSM.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mau_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } mau_err_e;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int FNC_HI = 5;
    localparam int FNC_LO = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int JTA_HI = 25;
    localparam int JTA_LO = 0;

    // Opcodes decoded by the control FSM
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/ir_decode.sv
// Combinational field slicing of the instruction register.
// Ports: ir (in, 32) ; opc, fnc (out, 6) ; rs, rt, rd (out, 5) ;
//        imm (out, 16) ; jta (out, 26).
module ir_decode
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  opc,
    output logic [5:0]  fnc,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [25:0] jta
);

    assign opc = ir[OPC_HI:OPC_LO];
    assign fnc = ir[FNC_HI:FNC_LO];
    assign rs  = ir[RS_HI:RS_LO];
    assign rt  = ir[RT_HI:RT_LO];
    assign rd  = ir[RD_HI:RD_LO];
    assign imm = ir[IMM_HI:IMM_LO];
    assign jta = ir[JTA_HI:JTA_LO];

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access / IR-MDR stage of the multicycle MIPS datapath.
// Turns the control unit's per-cycle memory commands into a req/ack
// transaction on the unified memory bus, captures read data into IR or MDR,
// decodes IR fields for the controller and raises busy while an access runs.
// Ports:
//   clk, rst                         clock, async active-high reset
//   InstData, MemRead, MemWrite,
//   IRWrite                          control commands
//   pc, alu_z, wdata                 fetch address, data address, store data
//   mem_req/we/addr/wdata, mem_rdata,
//   mem_ack                          memory bus
//   busy                             controller stall
//   ir, mdr                          instruction / memory data registers
//   opc, fnc, rs, rt, rd, imm, jta   IR fields
//   err                              sticky error code
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              InstData,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_z,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic [5:0]        opc,
    output logic [5:0]        fnc,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm,
    output logic [25:0]       jta,
    output logic [1:0]        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mau_state_e        state;
    logic [CW-1:0]     cnt;
    logic              dest;     // 1: read lands in IR, 0: in MDR
    logic              cmd;
    logic [ADDR_W-1:0] addr;

    assign cmd  = MemRead | MemWrite;
    assign addr = InstData ? alu_z : pc;

    // Stall in the command cycle itself; DONE deliberately reports not busy.
    assign busy = (state == ACCESS) | ((state == IDLE) & cmd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dest      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ir        <= '0;
            mdr       <= '0;
            err       <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd) begin
                        if (MemRead & MemWrite) begin
                            if (err == ERR_NONE) err <= ERR_ILLEGAL;
                        end else if (addr[1:0] != 2'b00) begin
                            if (err == ERR_NONE) err <= ERR_MISALIGN;
                        end else begin
                            mem_addr  <= addr;
                            mem_wdata <= wdata;
                            mem_we    <= MemWrite;
                            dest      <= IRWrite & MemRead;
                            cnt       <= CW'(TIMEOUT);
                            mem_req   <= 1'b1;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Ack is checked first so it wins over an expiring counter.
                    if (mem_ack) begin
                        if (!mem_we) begin
                            if (dest) ir  <= mem_rdata;
                            else      mdr <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CW'(1)) begin
                        // Last allowed cycle without ack: req was high TIMEOUT cycles.
                        if (err == ERR_NONE) err <= ERR_TIMEOUT;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    ir_decode u_ir_decode (
        .ir  (ir),
        .opc (opc),
        .fnc (fnc),
        .rs  (rs),
        .rt  (rt),
        .rd  (rd),
        .imm (imm),
        .jta (jta)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of directed accesses plus
// hand-written timeout, error and reset-mid-access sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        InstData, MemRead, MemWrite, IRWrite;
    logic [31:0] pc, alu_z, wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic [31:0] ir, mdr;
    logic [5:0]  opc, fnc;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] jta;
    logic [1:0]  err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .InstData(InstData), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .pc(pc), .alu_z(alu_z), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .ir(ir), .mdr(mdr),
        .opc(opc), .fnc(fnc), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .jta(jta),
        .err(err)
    );

    typedef struct {
        logic        inst_data, rd_c, wr_c, irw;
        logic [31:0] pc, alu_z, wdata;
        int          delay;        // wait cycles before ack
        logic [31:0] rdata;
        logic [31:0] e_addr, e_ir, e_mdr;
        logic [5:0]  e_opc, e_fnc;
        logic [4:0]  e_rs, e_rt, e_rd;
        logic [15:0] e_imm;
        logic [25:0] e_jta;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        InstData = 0; MemRead = 0; MemWrite = 0; IRWrite = 0;
        mem_ack = 0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        InstData = v.inst_data; MemRead = v.rd_c; MemWrite = v.wr_c; IRWrite = v.irw;
        pc = v.pc; alu_z = v.alu_z; wdata = v.wdata;
        #1;
        chk("busy_cmd", busy, 1);
        tick();
        idle_inputs();
        chk("req_rise", mem_req, 1);
        chk("addr", mem_addr, v.e_addr);
        chk("we", mem_we, v.wr_c);
        chk("wdata", mem_wdata, v.wdata);
        chk("busy_access", busy, 1);
        for (int d = 0; d < v.delay; d++) begin
            tick();
            chk("req_hold", mem_req, 1);
            chk("addr_hold", mem_addr, v.e_addr);
        end
        mem_ack = 1'b1; mem_rdata = v.rdata;
        tick();
        idle_inputs();
        chk("busy_done", busy, 0);
        chk("req_done", mem_req, 0);
        chk("ir", ir, v.e_ir);
        chk("mdr", mdr, v.e_mdr);
        chk("opc", opc, v.e_opc);
        chk("fnc", fnc, v.e_fnc);
        chk("rs", rs, v.e_rs);
        chk("rt", rt, v.e_rt);
        chk("rd", rd, v.e_rd);
        chk("imm", imm, v.e_imm);
        chk("jta", jta, v.e_jta);
        tick();
        chk("req_idle", mem_req, 0);
    endtask

    initial begin
        int n;
        vec_t fv;
        //          id rd wr irw pc            alu_z         wdata         dly rdata         e_addr        e_ir          e_mdr         opc     fnc    rs rt rd imm       jta
        vecs[0] = '{0, 1, 0, 1, 32'h0000_0040, 32'h0,       32'h1111_1111, 2, 32'h8C22_0004, 32'h0000_0040, 32'h8C22_0004, 32'h0,       6'h23, 6'h04, 1, 2, 0, 16'h0004, 26'h022_0004};
        vecs[1] = '{1, 0, 1, 1, 32'h0,       32'h0000_0100, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, 32'h0000_0100, 32'h8C22_0004, 32'h0,       6'h23, 6'h04, 1, 2, 0, 16'h0004, 26'h022_0004};
        vecs[2] = '{1, 1, 0, 0, 32'h0,       32'h0000_0104, 32'h2222_2222, 0, 32'h1234_5678, 32'h0000_0104, 32'h8C22_0004, 32'h1234_5678, 6'h23, 6'h04, 1, 2, 0, 16'h0004, 26'h022_0004};
        vecs[3] = '{0, 1, 0, 1, 32'h0000_0044, 32'h0,       32'h3333_3333, 0, 32'h0085_1020, 32'h0000_0044, 32'h0085_1020, 32'h1234_5678, 6'h00, 6'h20, 4, 5, 2, 16'h1020, 26'h085_1020};
        // ack on the cycle the counter expires: ack wins
        vecs[4] = '{1, 1, 0, 0, 32'h0,       32'h0000_0108, 32'h4444_4444, 14, 32'hCAFE_F00D, 32'h0000_0108, 32'h0085_1020, 32'hCAFE_F00D, 6'h00, 6'h20, 4, 5, 2, 16'h1020, 26'h085_1020};

        pc = 0; alu_z = 0; wdata = 0;
        do_reset();

        // reset state
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ir", ir, 0);
        chk("rst_mdr", mdr, 0);
        chk("rst_err", err, 0);
        chk("rst_opc", opc, 0);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        chk("err_after_table", err, 0);

        // Timeout: read with no ack
        InstData = 1; MemRead = 1; IRWrite = 0; alu_z = 32'h300;
        tick();
        idle_inputs();
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("timeout_req_cycles", n, 15);
        chk("timeout_err", err, 2'b10);
        chk("timeout_ir", ir, 32'h0085_1020);
        chk("timeout_mdr", mdr, 32'hCAFE_F00D);
        // later valid access still completes
        fv = vecs[0];
        fv.e_mdr = 32'hCAFE_F00D;
        run_vec(fv);
        chk("timeout_err_kept", err, 2'b10);

        // Misaligned while err already set: first code kept
        InstData = 1; MemRead = 1; alu_z = 32'h102;
        tick();
        idle_inputs();
        chk("sticky_err", err, 2'b10);
        chk("misalign_no_req_a", mem_req, 0);

        // Misaligned after reset
        do_reset();
        InstData = 1; MemRead = 1; alu_z = 32'h102;
        tick();
        idle_inputs();
        chk("misalign_err", err, 2'b01);
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_req !== 1'b0) n++;
            tick();
        end
        chk("misalign_no_req", n, 0);

        // Read and write together
        do_reset();
        InstData = 0; MemRead = 1; MemWrite = 1; pc = 32'h40;
        tick();
        idle_inputs();
        chk("illegal_err", err, 2'b11);
        chk("illegal_no_req", mem_req, 0);
        tick();
        chk("illegal_no_req2", mem_req, 0);

        // Reset in the second wait cycle of a fetch
        do_reset();
        InstData = 0; MemRead = 1; IRWrite = 1; pc = 32'h40;
        tick();
        idle_inputs();
        chk("rma_req_up", mem_req, 1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rma_req_async", mem_req, 0);
        chk("rma_ir", ir, 0);
        chk("rma_busy", busy, 0);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h8C22_0004;
        tick();
        idle_inputs();
        chk("late_ack_ir", ir, 0);
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_busy", busy, 0);
        tick();
        chk("late_ack_ir2", ir, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
